// File: rtl/clock_freq_meter.sv
// clock_freq_meter: counts rising edges of an asynchronous clock (sig_in) over a
// fixed gate window of clk_base cycles and publishes the count once per window.
// Optional dead-clock detection is compiled in with `define CLK_STALL_DET_EN.
//
// state | meaning
// IDLE  | not measuring, waiting for enable
// ARM   | waiting for an aligning sig_in edge (not counted)
// GATE  | counting sig_in edges for GATE_CYCLES cycles
// DONE  | one cycle, publish the result
module clock_freq_meter #(
  parameter int GATE_CYCLES  = 1000,
  parameter int COUNT_W      = 16,
  parameter int STALL_CYCLES = 256
) (
  input  logic               clk_base,
  input  logic               rst_n,
  input  logic               sig_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] meas_count,
  output logic               meas_ovf,
  output logic               meas_valid,
  output logic               busy,
  output logic               clk_stall
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sync1;
  logic                sync2;
  logic                prev;
  logic                rise;
  logic                load_meas;
  logic [GATE_W-1:0]   gate_cnt;
  logic [COUNT_W-1:0]  edge_cnt;
  logic                ovf;

  // Two-flop synchronizer for sig_in plus edge register for rise detection.
  always_ff @(posedge clk_base) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // State register.
  always_ff @(posedge clk_base) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode, busy and the publish strobe.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    load_meas = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ARM;
      end
      ARM: begin
        busy = 1'b1;
        if (!enable)   state_nxt = IDLE;
        else if (rise) state_nxt = GATE;
      end
      GATE: begin
        busy = 1'b1;
        if (!enable)                    state_nxt = IDLE;
        else if (gate_cnt == GATE_LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        load_meas = 1'b1;
        state_nxt = enable ? ARM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate timer and saturating edge counter; window restarts on the aligning edge.
  always_ff @(posedge clk_base) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (state == ARM && rise) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if (state == GATE) begin
      if (gate_cnt != GATE_LAST) gate_cnt <= gate_cnt + GATE_W'(1);
      if (rise) begin
        if (edge_cnt == {COUNT_W{1'b1}}) ovf <= 1'b1;
        else                             edge_cnt <= edge_cnt + COUNT_W'(1);
      end
    end
  end

  // Result registers; meas_valid rises together with the new count.
  always_ff @(posedge clk_base) begin
    if (!rst_n) begin
      meas_count <= '0;
      meas_ovf   <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= load_meas;
      if (load_meas) begin
        meas_count <= edge_cnt;
        meas_ovf   <= ovf;
      end
    end
  end

`ifdef CLK_STALL_DET_EN
  localparam int IDLE_W = $clog2(STALL_CYCLES + 1);
  localparam logic [IDLE_W-1:0] STALL_MAX = IDLE_W'(STALL_CYCLES);

  logic [IDLE_W-1:0] idle_cnt;

  // Cycles since the last detected edge, independent of FSM state.
  always_ff @(posedge clk_base) begin
    if (!rst_n)                 idle_cnt <= '0;
    else if (!enable || rise)   idle_cnt <= '0;
    else if (idle_cnt != STALL_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  assign clk_stall = (idle_cnt == STALL_MAX);
`else
  assign clk_stall = 1'b0;
`endif

endmodule

// File: tb/tb_clock_freq_meter.sv
// Directed bench for clock_freq_meter: a default instance (period-6 input) and a
// narrow-counter instance (COUNT_W=4, GATE_CYCLES=100, period-2 input).
module tb_clock_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_a, sig_b;
  logic        enable_a, enable_b;
  logic [15:0] count_a;
  logic        ovf_a, valid_a, busy_a, stall_a;
  logic [3:0]  count_b;
  logic        ovf_b, valid_b, busy_b, stall_b;

  int half_a = 0, half_b = 0;
  int cnt_a = 0, cnt_b = 0;
  int n_vec = 0, n_err = 0;

  logic       sat_seen = 1'b0;
  logic [3:0] sat_count = '0;
  logic       sat_ovf = 1'b0;

`ifdef CLK_STALL_DET_EN
  localparam logic STALL_EXP = 1'b1;
`else
  localparam logic STALL_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  clock_freq_meter u_dut (
    .clk_base(clk), .rst_n(rst_n), .sig_in(sig_a), .enable(enable_a),
    .meas_count(count_a), .meas_ovf(ovf_a), .meas_valid(valid_a),
    .busy(busy_a), .clk_stall(stall_a)
  );

  clock_freq_meter #(.GATE_CYCLES(100), .COUNT_W(4), .STALL_CYCLES(256)) u_sat (
    .clk_base(clk), .rst_n(rst_n), .sig_in(sig_b), .enable(enable_b),
    .meas_count(count_b), .meas_ovf(ovf_b), .meas_valid(valid_b),
    .busy(busy_b), .clk_stall(stall_b)
  );

  // Input clock generators: toggle every half_x clk cycles, hold when half_x is 0.
  always begin
    @(negedge clk);
    if (half_a != 0) begin
      if (cnt_a >= half_a - 1) begin sig_a = ~sig_a; cnt_a = 0; end
      else cnt_a++;
    end
    if (half_b != 0) begin
      if (cnt_b >= half_b - 1) begin sig_b = ~sig_b; cnt_b = 0; end
      else cnt_b++;
    end
  end

  // Capture the most recent result of the saturating instance.
  always begin
    @(posedge clk);
    #1;
    if (valid_b) begin
      sat_seen  = 1'b1;
      sat_count = count_b;
      sat_ovf   = ovf_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for a meas_valid pulse on the default instance; tracks busy dropping.
  task automatic wait_valid(input int max_cyc, output logic ok, output logic busy_dropped);
    ok = 1'b0;
    busy_dropped = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step(1);
      if (!busy_a) busy_dropped = 1'b1;
      if (valid_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok, dropped;
    int pulses;

    rst_n = 1'b0; enable_a = 1'b1; enable_b = 1'b1;
    sig_a = 1'b0; sig_b = 1'b0;
    half_a = 1; half_b = 1;

    // Reset with toggling input and enable high.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_outs_a", {count_a, ovf_a, valid_a, busy_a, stall_a}, 32'd0);
    end
    check("reset_outs_b", {count_b, ovf_b, valid_b, busy_b, stall_b}, 32'd0);

    half_a = 3; half_b = 1;
    rst_n = 1'b1;

    // Nominal: period 6 over 1000 cycles.
    step(2);
    check("busy_after_enable", busy_a, 1'b1);
    wait_valid(1300, ok, dropped);
    check("nominal_valid_seen", ok, 1'b1);
    check("nominal_count", count_a, 32'd166);
    check("nominal_ovf", ovf_a, 1'b0);
    check("nominal_busy_held", dropped, 1'b0);
    step(1);
    check("valid_one_cycle", valid_a, 1'b0);

    // Back-to-back windows.
    for (int w = 0; w < 2; w++) begin
      wait_valid(1300, ok, dropped);
      check("b2b_valid_seen", ok, 1'b1);
      check("b2b_count", count_a, 32'd166);
      check("b2b_busy_held", dropped, 1'b0);
    end

    // Saturation instance has produced several windows by now.
    check("sat_seen", sat_seen, 1'b1);
    check("sat_count", sat_count, 32'd15);
    check("sat_ovf", sat_ovf, 1'b1);

    // Abort mid-gate: roughly gate_cnt 500 after the last publish.
    step(505);
    check("abort_busy_before", busy_a, 1'b1);
    enable_a = 1'b0;
    step(1);
    check("abort_idle_next", busy_a, 1'b0);
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      if (valid_a) pulses++;
    end
    check("abort_no_valid", pulses, 32'd0);
    check("abort_count_hold", count_a, 32'd166);
    check("abort_ovf_hold", ovf_a, 1'b0);

    // Stall: stop the input right after a rising edge.
    enable_a = 1'b1;
    for (int i = 0; i < 20 && !sig_a; i++) step(1);
    check("stall_rise_found", sig_a, 1'b1);
    half_a = 0;
    sig_a = 1'b0;
    step(240);
    check("stall_early", stall_a, 1'b0);
    step(40);
    check("stall_flag", stall_a, STALL_EXP);
    step(1000);
    check("stall_busy_arm", busy_a, 1'b1);
    check("stall_flag_held", stall_a, STALL_EXP);
    cnt_a = 0;
    half_a = 3;
    step(12);
    check("stall_cleared", stall_a, 1'b0);

    // Recovery: first full window after the input restarts.
    wait_valid(1300, ok, dropped);
    check("recover_valid_seen", ok, 1'b1);
    check("recover_count", count_a, 32'd166);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
